// File: rtl/sobel_xy_stream.sv
// Streaming 3x3 Sobel engine: Gx and Gy from two line buffers, mode-selected output.
// Latency 3 cycles (window, gradients, output); no backpressure, gaps in valid_i pass through.
module sobel_xy_stream #(
  parameter int LINE_WIDTH   = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int PIXEL_DEPTH  = 8,
  parameter int COORD_WIDTH  = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  input  logic                   sof_i,
  input  logic [PIXEL_DEPTH-1:0] pixel_i,
  input  logic [1:0]             mode_i,
  input  logic [PIXEL_DEPTH-1:0] threshold_i,
  output logic                   valid_o,
  output logic [PIXEL_DEPTH-1:0] pixel_o,
  output logic                   sof_o,
  output logic [COORD_WIDTH-1:0] row_o,
  output logic [COORD_WIDTH-1:0] col_o
);

  localparam int GW   = PIXEL_DEPTH + 4;
  localparam int AW   = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int MAXV = (2 ** PIXEL_DEPTH) - 1;

  logic [COORD_WIDTH-1:0] row_cnt, col_cnt, cur_row, cur_col;
  logic                   primed;
  logic [AW-1:0]          addr;

  logic [PIXEL_DEPTH-1:0] lb0 [LINE_WIDTH];
  logic [PIXEL_DEPTH-1:0] lb1 [LINE_WIDTH];
  logic [PIXEL_DEPTH-1:0] w [3][3];

  logic                   s1_vld, s1_mask, s1_sof;
  logic [COORD_WIDTH-1:0] s1_row, s1_col;
  logic [1:0]             s1_mode;
  logic [PIXEL_DEPTH-1:0] s1_thr;

  logic                   s2_vld, s2_mask, s2_sof;
  logic [COORD_WIDTH-1:0] s2_row, s2_col;
  logic [1:0]             s2_mode;
  logic [PIXEL_DEPTH-1:0] s2_thr;
  logic [GW-1:0]          s2_ax, s2_ay;

  logic signed [GW-1:0]   gx, gy;
  logic [GW-1:0]          ax, ay, sum;
  logic [PIXEL_DEPTH-1:0] result;

  function automatic logic signed [GW-1:0] ext(input logic [PIXEL_DEPTH-1:0] p);
    return $signed({{(GW-PIXEL_DEPTH){1'b0}}, p});
  endfunction

  function automatic logic [PIXEL_DEPTH-1:0] sat(input logic [GW-1:0] v);
    return (v > GW'(MAXV)) ? {PIXEL_DEPTH{1'b1}} : v[PIXEL_DEPTH-1:0];
  endfunction

  // A start-of-frame strobe restarts coordinates on the very pixel it arrives with.
  assign cur_row = sof_i ? '0 : row_cnt;
  assign cur_col = sof_i ? '0 : col_cnt;
  assign addr    = cur_col[AW-1:0];

  // Line-buffer RAM is deliberately not reset; the border mask hides stale lines.
  always_ff @(posedge clk) begin
    if (valid_i && !reset) begin
      lb1[addr] <= pixel_i;
      lb0[addr] <= lb1[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt <= '0;
      col_cnt <= '0;
      primed  <= 1'b0;
      s1_vld  <= 1'b0;
      s1_mask <= 1'b0;
      s1_sof  <= 1'b0;
      s1_row  <= '0;
      s1_col  <= '0;
      s1_mode <= '0;
      s1_thr  <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[r][c] <= '0;
    end else begin
      s1_vld <= valid_i;
      if (valid_i) begin
        for (int r = 0; r < 3; r++) begin
          w[r][0] <= w[r][1];
          w[r][1] <= w[r][2];
        end
        w[0][2] <= lb0[addr];
        w[1][2] <= lb1[addr];
        w[2][2] <= pixel_i;
        s1_mask <= (cur_row < COORD_WIDTH'(2)) || (cur_col < COORD_WIDTH'(2));
        // A counter-wrapped (0,0) marks a frame start, but not the first pixel after reset.
        s1_sof  <= sof_i || (primed && cur_row == '0 && cur_col == '0);
        s1_row  <= cur_row - 1'b1;
        s1_col  <= cur_col - 1'b1;
        s1_mode <= mode_i;
        s1_thr  <= threshold_i;
        primed  <= 1'b1;
        if (cur_col == COORD_WIDTH'(LINE_WIDTH - 1)) begin
          col_cnt <= '0;
          row_cnt <= (cur_row == COORD_WIDTH'(FRAME_HEIGHT - 1)) ? '0 : cur_row + 1'b1;
        end else begin
          col_cnt <= cur_col + 1'b1;
          row_cnt <= cur_row;
        end
      end
    end
  end

  always_comb begin
    gx = (ext(w[0][2]) + (ext(w[1][2]) <<< 1) + ext(w[2][2]))
       - (ext(w[0][0]) + (ext(w[1][0]) <<< 1) + ext(w[2][0]));
    gy = (ext(w[2][0]) + (ext(w[2][1]) <<< 1) + ext(w[2][2]))
       - (ext(w[0][0]) + (ext(w[0][1]) <<< 1) + ext(w[0][2]));
    ax = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_vld  <= 1'b0;
      s2_mask <= 1'b0;
      s2_sof  <= 1'b0;
      s2_row  <= '0;
      s2_col  <= '0;
      s2_mode <= '0;
      s2_thr  <= '0;
      s2_ax   <= '0;
      s2_ay   <= '0;
    end else begin
      s2_vld  <= s1_vld;
      s2_mask <= s1_mask;
      s2_sof  <= s1_sof;
      s2_row  <= s1_row;
      s2_col  <= s1_col;
      s2_mode <= s1_mode;
      s2_thr  <= s1_thr;
      s2_ax   <= ax;
      s2_ay   <= ay;
    end
  end

  always_comb begin
    sum    = s2_ax + s2_ay;
    result = '0;
    case (s2_mode)
      2'd0:    result = sat(s2_ax);
      2'd1:    result = sat(s2_ay);
      2'd2:    result = sat(sum);
      default: result = (sum >= GW'(s2_thr)) ? {PIXEL_DEPTH{1'b1}} : '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o <= 1'b0;
      pixel_o <= '0;
      sof_o   <= 1'b0;
      row_o   <= '0;
      col_o   <= '0;
    end else begin
      valid_o <= s2_vld;
      sof_o   <= s2_vld && s2_sof;
      pixel_o <= (s2_vld && !s2_mask) ? result : '0;
      row_o   <= (s2_vld && !s2_mask) ? s2_row : '0;
      col_o   <= (s2_vld && !s2_mask) ? s2_col : '0;
    end
  end

endmodule

// File: tb/tb_sobel_xy_stream.sv
// Randomized bench for sobel_xy_stream against a frame-array Sobel reference model.
module tb_sobel_xy_stream;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int PD = 8;
  localparam int CW = 13;

  logic          clk = 1'b0;
  logic          reset, valid_i, sof_i;
  logic [PD-1:0] pixel_i, threshold_i;
  logic [1:0]    mode_i;
  logic          valid_o, sof_o;
  logic [PD-1:0] pixel_o;
  logic [CW-1:0] row_o, col_o;

  always #5 clk = ~clk;

  sobel_xy_stream #(.LINE_WIDTH(W), .FRAME_HEIGHT(H), .PIXEL_DEPTH(PD), .COORD_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .sof_i(sof_i), .pixel_i(pixel_i),
    .mode_i(mode_i), .threshold_i(threshold_i), .valid_o(valid_o), .pixel_o(pixel_o),
    .sof_o(sof_o), .row_o(row_o), .col_o(col_o)
  );

  typedef struct {
    int at;
    bit sof;
    int pix;
    int row;
    int col;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0, errors = 0;
  int   ncyc = 0, n_in = 0, n_out = 0;
  bit   mon_en = 1'b0;
  int   img[H][W];
  int   mr = 0, mc = 0;
  bit   primed = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, ncyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  always @(negedge clk) begin
    ncyc++;
    if (mon_en) begin
      if (q.size() > 0 && q[0].at == ncyc) begin
        e = q.pop_front();
        n_out++;
        chk("valid_o", {31'b0, valid_o}, 1);
        chk("pixel_o", {24'b0, pixel_o}, e.pix);
        chk("sof_o",   {31'b0, sof_o},   {31'b0, e.sof});
        chk("row_o",   {19'b0, row_o},   e.row);
        chk("col_o",   {19'b0, col_o},   e.col);
      end else begin
        chk("idle_valid_o", {31'b0, valid_o}, 0);
        chk("idle_pixel_o", {24'b0, pixel_o}, 0);
        chk("idle_sof_o",   {31'b0, sof_o},   0);
        chk("idle_row_o",   {19'b0, row_o},   0);
        chk("idle_col_o",   {19'b0, col_o},   0);
      end
    end
  end

  // Reference: full-frame image array; window read straight from image coordinates.
  task automatic model_accept(input bit s, input int pix, input int md, input int th);
    int r, c, gx, gy, ax, ay, val, wt;
    bit masked;
    exp_t x;
    r = s ? 0 : mr;
    c = s ? 0 : mc;
    img[r][c] = pix;
    masked = (r < 2) || (c < 2);
    val = 0;
    if (!masked) begin
      gx = 0;
      gy = 0;
      for (int k = 0; k < 3; k++) begin
        wt = (k == 1) ? 2 : 1;
        gx += wt * (img[r-2+k][c] - img[r-2+k][c-2]);
        gy += wt * (img[r][c-2+k] - img[r-2][c-2+k]);
      end
      ax = iabs(gx);
      ay = iabs(gy);
      case (md)
        0:       val = sat(ax);
        1:       val = sat(ay);
        2:       val = sat(ax + ay);
        default: val = (ax + ay >= th) ? 255 : 0;
      endcase
    end
    x.at  = ncyc + 4;
    x.pix = val;
    x.sof = s || (primed && r == 0 && c == 0);
    x.row = masked ? 0 : r - 1;
    x.col = masked ? 0 : c - 1;
    q.push_back(x);
    primed = 1'b1;
    n_in++;
    mc = c + 1;
    mr = r;
    if (mc == W) begin
      mc = 0;
      mr = (r + 1 == H) ? 0 : r + 1;
    end
  endtask

  task automatic drive(input bit v, input bit s, input int pix, input int md, input int th, input bit rst);
    reset       = rst;
    valid_i     = v;
    sof_i       = s;
    pixel_i     = pix[7:0];
    mode_i      = md[1:0];
    threshold_i = th[7:0];
    if (rst) begin
      while (q.size() > 0 && q[q.size()-1].at >= ncyc + 2) begin
        void'(q.pop_back());
        n_in--;
      end
      mr = 0;
      mc = 0;
      primed = 1'b0;
    end else if (v) begin
      model_accept(s, pix, md, th);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int gen(input int kind, input int r, input int c);
    case (kind)
      0:       return 8'h80;
      1:       return (c < W / 2) ? 0 : 255;
      2:       return c + r * 0;
      default: return $urandom_range(0, 255);
    endcase
  endfunction

  task automatic run_pixels(input int n, input int kind, input int md, input int th,
                            input int gap, input bit first_sof);
    bit s;
    int r, c, m, t;
    for (int i = 0; i < n; i++) begin
      s = first_sof && (i == 0);
      r = s ? 0 : mr;
      c = s ? 0 : mc;
      m = (md < 0) ? $urandom_range(0, 3) : md;
      t = (th < 0) ? $urandom_range(0, 255) : th;
      drive(1'b1, s, gen(kind, r, c), m, t, 1'b0);
      for (int g = 0; g < gap; g++)
        drive(1'b0, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 3), 0, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; sof_i = 1'b0;
    pixel_i = '0; mode_i = '0; threshold_i = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b0);

    // Flat frame, random mode per pixel: every output is zero.
    run_pixels(W * H, 0, -1, -1, 0, 1'b1);
    // Vertical step edge in |Gx| then |Gy|.
    run_pixels(W * H, 1, 0, 0, 0, 1'b1);
    run_pixels(W * H, 1, 1, 0, 0, 1'b1);
    // Horizontal ramp: L1, threshold at and above the gradient, random mode switches.
    run_pixels(W * H, 2, 2, 0, 0, 1'b1);
    run_pixels(W * H, 2, 3, 8, 0, 1'b1);
    run_pixels(W * H, 2, 3, 9, 0, 1'b1);
    run_pixels(W * H, 2, -1, 8, 0, 1'b1);
    // Random frames; second one starts by natural counter wrap.
    run_pixels(W * H, 3, -1, -1, 0, 1'b1);
    run_pixels(W * H, 3, -1, -1, 0, 1'b0);
    // 1-of-3 gating with a mid-frame resync at (5,7).
    run_pixels(W * 5 + 7, 3, -1, -1, 2, 1'b0);
    run_pixels(W * 3, 3, -1, -1, 2, 1'b1);
    // Reset mid-line, restart without sof_i.
    run_pixels(W * 3 + 5, 3, -1, -1, 0, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 0, 1'b1);
    run_pixels(W * H, 3, -1, -1, 0, 1'b0);
    // Reset together with a valid pixel: the pixel is discarded.
    run_pixels(W + 3, 3, -1, -1, 1, 1'b0);
    drive(1'b1, 1'b0, 77, 2, 0, 1'b1);
    run_pixels(W * 4, 3, -1, -1, 0, 1'b1);

    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
    chk("out_count", n_out, n_in);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sobel_xy_stream.md
Name: sobel_xy_stream

Overview:
- Streaming 3x3 Sobel edge engine.
- Successor to the fixed single-kernel Sobel convolver: both Gx and Gy are computed in one pass.
- Run-time selectable output mode: |Gx|, |Gy|, L1 magnitude, or binary threshold.
- Built-in row/col tracking, border masking and start-of-frame resync.
- Sits between yuv_convert (consumes Y) and image_dumper / VGA output path. One pixel in per valid_i, one pixel out per valid_o, no backpressure.

Parameters:
- LINE_WIDTH, 640, pixels per line; depth of each line buffer.
- FRAME_HEIGHT, 480, lines per frame.
- PIXEL_DEPTH, 8, bits per luminance sample, in and out.
- COORD_WIDTH, 13, width of row/col counters and coordinate outputs.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- valid_i  in  1  input pixel strobe.
- sof_i  in  1  start of frame; meaningful only with valid_i.
- pixel_i  in  PIXEL_DEPTH  luminance sample, unsigned.
- mode_i  in  2  0=|Gx|, 1=|Gy|, 2=|Gx|+|Gy|, 3=threshold.
- threshold_i  in  PIXEL_DEPTH  threshold for mode 3.
- valid_o  out  1  output strobe.
- pixel_o  out  PIXEL_DEPTH  edge value.
- sof_o  out  1  high with the output of input pixel (0,0).
- row_o  out  COORD_WIDTH  window-centre row = input row - 1; 0 when masked.
- col_o  out  COORD_WIDTH  window-centre col = input col - 1; 0 when masked.

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - Reset is synchronous and active-high.
  - On reset: valid_o=0, pixel_o=0, sof_o=0, row_o=0, col_o=0; row/col counters=0; window registers=0; pipeline valid bits cleared.
  - Line-buffer RAM contents are not cleared; border masking covers stale data.
- Coordinates:
  - On each valid_i, the current pixel takes coordinates (row,col).
  - col increments and wraps LINE_WIDTH-1 -> 0; row increments on that wrap, and row wraps FRAME_HEIGHT-1 -> 0.
  - valid_i && sof_i forces the pixel to (0,0); counters continue from there. This is a mid-frame resync with no flush.
- Line buffers:
  - Two buffers of LINE_WIDTH x PIXEL_DEPTH, addressed by col.
  - On valid_i: read lb1[col] (row-1) and lb0[col] (row-2); write lb1[col]<=pixel_i and lb0[col]<=old lb1[col]. Read-before-write at the same address.
- Window:
  - 3x3 shift window w[r][c], r,c in 0..2; row 2 and col 2 are newest. Shifts only on valid_i.
  - The window whose bottom-right is the current input is complete iff row>=2 && col>=2; otherwise the output value is forced to 0.
- Arithmetic:
  - Gx = (w0,2+2w1,2+w2,2)-(w0,0+2w1,0+w2,0).
  - Gy = (w2,0+2w2,1+w2,2)-(w0,0+2w0,1+w0,2).
  - Signed, PIXEL_DEPTH+4 bits, no overflow.
  - Mode 0: |Gx| saturated to 2^PIXEL_DEPTH-1.
  - Mode 1: |Gy|, saturated the same way.
  - Mode 2: |Gx|+|Gy|, saturated.
  - Mode 3: (|Gx|+|Gy|) >= threshold_i ? all-ones : 0.
  - mode_i and threshold_i are sampled with valid_i and pipelined with the pixel, so a mode change takes effect exactly on the pixel accepted in that cycle.
- Latency and flow:
  - Fixed 3 cycles: valid_i at cycle N -> valid_o at N+3. Stages are window capture, gradients, mode/saturate/output register.
  - Gaps in valid_i propagate as gaps in valid_o. No throughput loss: back-to-back input gives back-to-back output.
  - When valid_o=0, pixel_o, row_o, col_o and sof_o hold 0.
  - One output per input; total outputs per frame = LINE_WIDTH*FRAME_HEIGHT.
- Edge cases:
  - sof_i without valid_i: ignored.
  - Reset mid-frame: in-flight pixels are dropped (no valid_o for them); the next valid_i is treated as (0,0).
  - Simultaneous reset and valid_i: reset wins and the pixel is discarded.

Test Plan:
1. Constant frame, all pixels = 0x80, all modes -> every pixel_o = 0. valid_o count = 307200. First valid_o exactly 3 cycles after first valid_i.
2. Vertical step edge (cols <320 = 0, cols >=320 = 255), mode 0 -> pixel_o = 255 at input cols 320 and 321 for rows >=2 (col_o 319/320), 0 elsewhere. Same frame in mode 1 -> all 0.
3. Horizontal ramp pixel=col, mode 2 -> |Gx| = 8, |Gy| = 0, so pixel_o = 8 for row>=2 && col>=2. pixel_o = 0 for input rows 0-1 and cols 0-1 (border mask).
4. Same ramp in mode 3 -> threshold_i = 8 gives pixel_o = 255 in the interior; threshold_i = 9 gives all 0. Switching mode_i 2->3 mid-line changes output exactly at the pixel accepted on the switch cycle.
5. valid_i gated 1-of-3 cycles plus sof_i asserted at input (100,50) -> outputs keep the same spacing. That pixel emits sof_o = 1 with row_o = col_o = 0. Next output at col_o = 0 on row 0, value 0.
6. reset pulsed for 1 cycle mid-line -> no valid_o for the 3 in-flight pixels. Next input maps to (0,0): masked output 0, with sof_o = 0 unless sof_i was given.
